// File: rtl/pwm_dac_pkg.sv
// ============================================================================
// Module      : pwm_dac_pkg
// Description : Shared constants and the offset-binary helpers for pwm_dac.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_dac_pkg;

  localparam int unsigned SAMPLE_BITS_DEF = 10;
  localparam int unsigned PWM_BITS_DEF    = 8;

  // Midscale code of a BITS-wide unsigned field (also the offset-binary zero).
  function automatic logic [31:0] midscale(input int unsigned bits);
    return 32'(1) << (bits - 1);
  endfunction

  // Two's complement -> offset binary: flip the sign bit, keep the rest.
  function automatic logic [31:0] to_ob(input logic [31:0] s, input int unsigned bits);
    logic [31:0] mask;
    mask = (32'(1) << bits) - 32'd1;
    return (s ^ midscale(bits)) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_dac_noise_shaper.sv
// ============================================================================
// Module      : pwm_dac_noise_shaper
// Description : First-order error feedback of the sub-PWM bits with duty
//               saturation; used only when PWM_DAC_DITHER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_dac_noise_shaper
  import pwm_dac_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int unsigned PWM_BITS    = PWM_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [SAMPLE_BITS-1:0] sample_ob,
  output logic [PWM_BITS-1:0]    duty
);

  localparam int unsigned FRAC = SAMPLE_BITS - PWM_BITS;

  logic [FRAC-1:0]   err_q, err_d;
  logic [FRAC:0]     sum;
  logic [PWM_BITS:0] duty_wide;

  always_comb begin
    sum       = {1'b0, err_q} + {1'b0, sample_ob[FRAC-1:0]};
    duty_wide = {1'b0, sample_ob[SAMPLE_BITS-1 -: PWM_BITS]} + {{PWM_BITS{1'b0}}, sum[FRAC]};
    // A carry out of full-scale hi would wrap to zero; clamp to MAX instead.
    duty      = duty_wide[PWM_BITS] ? '1 : duty_wide[PWM_BITS-1:0];
    err_d     = load ? sum[FRAC-1:0] : err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

endmodule

`default_nettype wire

// File: rtl/pwm_dac.sv
// ============================================================================
// Module      : pwm_dac
// Description : Signed sample to single-pin PWM with pending/current sample
//               registers; define PWM_DAC_DITHER_EN for noise shaping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int unsigned PWM_BITS    = PWM_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [SAMPLE_BITS-1:0] sample,
  input  logic                   sample_valid,
  output logic                   pwm_out,
  output logic                   frame_strobe,
  output logic                   overrun
);

  localparam logic [PWM_BITS-1:0]    CNT_MAX  = '1;
  localparam logic [PWM_BITS-1:0]    DUTY_RST = PWM_BITS'(midscale(PWM_BITS));
  localparam logic [SAMPLE_BITS-1:0] CUR_RST  = SAMPLE_BITS'(midscale(SAMPLE_BITS));

  logic [PWM_BITS-1:0]    cnt_q, cnt_d;
  logic [PWM_BITS-1:0]    duty_q, duty_d;
  logic [SAMPLE_BITS-1:0] cur_q, cur_d;
  logic [SAMPLE_BITS-1:0] pend_q, pend_d;
  logic                   pend_flag_q, pend_flag_d;
  logic                   pwm_q, pwm_d;

  logic                   load;
  logic [SAMPLE_BITS-1:0] ob;
  logic [SAMPLE_BITS-1:0] source;
  logic [PWM_BITS-1:0]    duty_next;

  assign ob     = SAMPLE_BITS'(to_ob(32'(sample), SAMPLE_BITS));
  assign load   = ena && (cnt_q == CNT_MAX);
  assign source = pend_flag_q ? pend_q : cur_q;

`ifdef PWM_DAC_DITHER_EN
  pwm_dac_noise_shaper #(
    .SAMPLE_BITS (SAMPLE_BITS),
    .PWM_BITS    (PWM_BITS)
  ) u_shaper (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .sample_ob (source),
    .duty      (duty_next)
  );
`else
  assign duty_next = source[SAMPLE_BITS-1 -: PWM_BITS];
`endif

  always_comb begin
    cnt_d       = cnt_q;
    duty_d      = duty_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    pwm_d       = pwm_q;

    if (ena) begin
      cnt_d = cnt_q + 1'b1;
      pwm_d = (cnt_q < duty_q);
    end

    if (load) begin
      cur_d  = source;
      duty_d = duty_next;
    end

    // A write coinciding with a load becomes pending for the following frame.
    if (sample_valid) begin
      pend_d      = ob;
      pend_flag_d = 1'b1;
    end else if (load) begin
      pend_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      duty_q      <= DUTY_RST;
      cur_q       <= CUR_RST;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      pwm_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign frame_strobe = load;
  assign overrun      = sample_valid && pend_flag_q && !load;

endmodule

`default_nettype wire

// File: tb/tb_pwm_dac.sv
// ============================================================================
// Module      : tb_pwm_dac
// Description : Directed self-checking bench for pwm_dac (honours PWM_DAC_DITHER_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_dac;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [9:0] sample = '0;
  logic       sample_valid = 1'b0;
  logic       pwm_out;
  logic       frame_strobe;
  logic       overrun;

  int n_vec  = 0;
  int n_fail = 0;

  int frame_hi [0:7];
  int strobe_total;
  int strobe_good;
  int overrun_seen;
  bit timeout;

  pwm_dac #(
    .SAMPLE_BITS (10),
    .PWM_BITS    (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .sample       (sample),
    .sample_valid (sample_valid),
    .pwm_out      (pwm_out),
    .frame_strobe (frame_strobe),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Leaves the bench on the negedge where reset is released (cnt = 0).
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sample_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1;
  endtask

  task automatic write_sample(input logic [9:0] v);
    sample = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Returns on the negedge of a cycle in which frame_strobe is high.
  task automatic wait_strobe();
    timeout = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (frame_strobe) return;
    end
    timeout = 1'b1;
  endtask

  // Called on a strobe negedge; records highs of the next n frames.
  task automatic count_frames(input int n);
    strobe_total = 0;
    strobe_good = 0;
    overrun_seen = 0;
    for (int f = 0; f < 8; f++) frame_hi[f] = 0;
    @(negedge clk);
    sample_valid = 1'b0;
    for (int i = 0; i < n * 256; i++) begin
      @(negedge clk);
      if (pwm_out) frame_hi[i / 256]++;
      if (frame_strobe) begin
        strobe_total++;
        if (i % 256 == 254) strobe_good++;
      end
      if (overrun) overrun_seen++;
    end
  endtask

  task automatic test_reset();
    int early;
    int first;
    early = 0;
    first = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    ena = 1'b1;
    #1;
    n_vec++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b expected 0", pwm_out); end
    n_vec++; if (frame_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b expected 0", frame_strobe); end
    n_vec++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 255; n++) begin
      @(negedge clk);
      if (frame_strobe) begin
        if (n == 255) first = 1;
        else early++;
      end
    end
    n_vec++; if (early !== 0) begin n_fail++; $display("FAIL reset_early_strobe: got %0d expected 0", early); end
    n_vec++; if (first !== 1) begin n_fail++; $display("FAIL reset_first_strobe: got %0d expected 1", first); end
    count_frames(2);
    n_vec++; if (frame_hi[0] !== 128) begin n_fail++; $display("FAIL idle_hi0: got %0d expected 128", frame_hi[0]); end
    n_vec++; if (frame_hi[1] !== 128) begin n_fail++; $display("FAIL idle_hi1: got %0d expected 128", frame_hi[1]); end
    n_vec++; if (strobe_good !== 2 || strobe_total !== 2) begin n_fail++; $display("FAIL idle_strobes: got %0d/%0d expected 2/2", strobe_good, strobe_total); end
    n_vec++; if (overrun_seen !== 0) begin n_fail++; $display("FAIL idle_overrun: got %0d expected 0", overrun_seen); end
  endtask

  task automatic test_full_scale();
    do_reset();
    write_sample(10'h1FF);
    wait_strobe();
    n_vec++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL pos_strobe_wait: got timeout expected strobe"); end
    count_frames(2);
    n_vec++; if (frame_hi[0] !== 255) begin n_fail++; $display("FAIL pos_full_hi0: got %0d expected 255", frame_hi[0]); end
    n_vec++; if (frame_hi[1] !== 255) begin n_fail++; $display("FAIL pos_full_hi1: got %0d expected 255", frame_hi[1]); end
    write_sample(10'h200);
    wait_strobe();
    n_vec++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL neg_strobe_wait: got timeout expected strobe"); end
    count_frames(2);
    n_vec++; if (frame_hi[0] !== 0) begin n_fail++; $display("FAIL neg_full_hi0: got %0d expected 0", frame_hi[0]); end
    n_vec++; if (frame_hi[1] !== 0) begin n_fail++; $display("FAIL neg_full_hi1: got %0d expected 0", frame_hi[1]); end
  endtask

  task automatic test_dither();
    int exp_hi;
    do_reset();
    write_sample(10'h001);
    wait_strobe();
    n_vec++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL dith_strobe_wait: got timeout expected strobe"); end
    count_frames(8);
    for (int f = 0; f < 8; f++) begin
`ifdef PWM_DAC_DITHER_EN
      exp_hi = (f % 4 == 3) ? 129 : 128;
`else
      exp_hi = 128;
`endif
      n_vec++;
      if (frame_hi[f] !== exp_hi) begin
        n_fail++;
        $display("FAIL plus_one_hi[%0d]: got %0d expected %0d", f, frame_hi[f], exp_hi);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    repeat (10) @(negedge clk);
    sample = 10'h100;
    sample_valid = 1'b1;
    #1;
    n_vec++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first_write: got %b expected 0", overrun); end
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (5) @(negedge clk);
    sample = 10'h300;
    sample_valid = 1'b1;
    #1;
    n_vec++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_second_write: got %b expected 1", overrun); end
    @(negedge clk);
    sample_valid = 1'b0;
    #1;
    n_vec++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pulse_end: got %b expected 0", overrun); end
    wait_strobe();
    n_vec++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL ovr_strobe_wait: got timeout expected strobe"); end
    count_frames(1);
    n_vec++; if (frame_hi[0] !== 64) begin n_fail++; $display("FAIL ovr_latest_hi: got %0d expected 64", frame_hi[0]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (5) @(negedge clk);
    write_sample(10'h100);
    wait_strobe();
    n_vec++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL b2b_strobe_wait: got timeout expected strobe"); end
    sample = 10'h300;
    sample_valid = 1'b1;
    #1;
    n_vec++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    count_frames(2);
    n_vec++; if (frame_hi[0] !== 192) begin n_fail++; $display("FAIL b2b_old_hi: got %0d expected 192", frame_hi[0]); end
    n_vec++; if (frame_hi[1] !== 64) begin n_fail++; $display("FAIL b2b_new_hi: got %0d expected 64", frame_hi[1]); end
    n_vec++; if (overrun_seen !== 0) begin n_fail++; $display("FAIL b2b_overrun_seen: got %0d expected 0", overrun_seen); end
  endtask

  task automatic test_ena_stall();
    int frozen_bad;
    int early;
    int first;
    frozen_bad = 0;
    early = 0;
    first = 0;
    do_reset();
    sample = 10'h100;
    sample_valid = 1'b1;
    for (int n = 1; n <= 265; n++) begin
      @(negedge clk);
      if (n == 1) sample_valid = 1'b0;
      if (n >= 101 && n <= 110 && pwm_out !== 1'b1) frozen_bad++;
      if (frame_strobe) begin
        if (n == 265) first = 1;
        else early++;
      end
      if (n == 100) ena = 1'b0;
      if (n == 110) ena = 1'b1;
    end
    n_vec++; if (frozen_bad !== 0) begin n_fail++; $display("FAIL stall_pwm_frozen: got %0d bad expected 0", frozen_bad); end
    n_vec++; if (early !== 0) begin n_fail++; $display("FAIL stall_early_strobe: got %0d expected 0", early); end
    n_vec++; if (first !== 1) begin n_fail++; $display("FAIL stall_stretched_strobe: got %0d expected 1", first); end
    repeat (50) @(negedge clk);
    n_vec++; if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL pre_reset_pwm: got %b expected 1", pwm_out); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL midframe_reset_pwm: got %b expected 0", pwm_out); end
    n_vec++; if (frame_strobe !== 1'b0) begin n_fail++; $display("FAIL midframe_reset_strobe: got %b expected 0", frame_strobe); end
    @(negedge clk);
    rst_n = 1'b1;
    early = 0;
    first = 0;
    for (int n = 1; n <= 255; n++) begin
      @(negedge clk);
      if (frame_strobe) begin
        if (n == 255) first = 1;
        else early++;
      end
    end
    n_vec++; if (early !== 0 || first !== 1) begin n_fail++; $display("FAIL rst_restart_strobe: got early=%0d first=%0d expected 0/1", early, first); end
    count_frames(1);
    n_vec++; if (frame_hi[0] !== 128) begin n_fail++; $display("FAIL rst_midscale_hi: got %0d expected 128", frame_hi[0]); end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_dither();
    test_overrun();
    test_back_to_back();
    test_ena_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
